io_clk_strobe_gen: RTL and testbench
====================================

// Module: io_clk_strobe_gen
//
// PURPOSE
//   Consumes the 8 candidate IO clocks produced by the IO clock generation stage:
//     [0] sys_clk, [3:1] src_clk2..0, [7:4] divided clks 3..0
//   Each of NUM_CH IO channels selects one source. The selected source is synchronized into
//   sys_clk and converted into single-cycle rise/fall strobes. IO peripherals use these strobes
//   as clock enables instead of clocking logic directly from the generated clocks.
//   A settle interval after every source change blanks the strobes, so a source switch never
//   produces a spurious or runt strobe.
//
// PARAMETERS
//   NUM_CH        4   number of IO channels (1..8)
//   SYNC_STAGES   2   synchronizer flops per source (>=2)
//   SETTLE_CYCLES 8   enabled sys_clk cycles that strobes stay blanked after enable/sel change (>=SYNC_STAGES+1)
//
// PORTS
//   sys_clk      in   1               system clock; the block's only clock
//   async_rst_n  in   1               asynchronous, active-low reset
//   clk_en       in   1               global clock enable
//   io_clk_in    in   8               candidate clocks; bit 0 = sys_clk (never sampled)
//   cfg_addr     in   $clog2(NUM_CH)  channel index for config read/write (1 bit when NUM_CH=1)
//   cfg_we       in   1               config write strobe
//   cfg_wdata    in   4               {enable, sel[2:0]}
//   cfg_rdata    out  4               config of channel cfg_addr, combinational
//   rise_strobe  out  NUM_CH          one-cycle pulse per rising edge of the selected source
//   fall_strobe  out  NUM_CH          one-cycle pulse per falling edge of the selected source
//   ch_ready     out  NUM_CH          channel in RUN; its strobes are valid
//
// BEHAVIOUR
//   Reset (async_rst_n=0, asynchronous):
//     - all channel configs = 4'b0000 (disabled, sel 0)
//     - synchronizer and history flops = 0
//     - FSM = DISABLED
//     - rise_strobe, fall_strobe, ch_ready = 0
//     - reset asserted mid-operation aborts SETTLE/RUN immediately
//   Synchronizer:
//     - one SYNC_STAGES chain per source 7..1, free-running (clk_en does not gate it)
//     - hist[s] = previous synced value of source s
//   Edge detection, per channel, registered:
//     - rise = synced & ~hist; fall = ~synced & hist
//     - source toggles between edges k-1 and k -> strobe high for the one cycle following edge k+SYNC_STAGES
//   FSM per channel (DISABLED / SETTLE / RUN), updates only when clk_en=1:
//     - DISABLED: strobes=0, ready=0. cfg write with enable=1 -> SETTLE; counter loaded with SETTLE_CYCLES.
//     - SETTLE: strobes=0, ready=0. Counter decrements each enabled cycle; reaching 0 -> RUN.
//     - RUN: ready=1; strobes follow edge detection.
//     - From SETTLE or RUN:
//         - write with enable=0 -> DISABLED next cycle
//         - write with enable=1 and a different sel -> SETTLE, counter reloaded
//         - write with identical data -> no state change, no counter reload
//   sel=0 (sys_clk): in RUN, rise_strobe=1 every enabled cycle and fall_strobe=0 (no sampling). SETTLE still applies.
//   clk_en=0: all strobes forced 0; FSM and counter hold; hist keeps tracking, so no stale edge is emitted on resume.
//     - edges occurring while clk_en=0 are dropped
//   Config writes:
//     - take effect at the next edge regardless of clk_en
//     - cfg_addr >= NUM_CH: write ignored, cfg_rdata = 0
//   cfg_we with a write in the same cycle as the counter reaching 0: the write wins (SETTLE restarts / DISABLED).
//   Strobes of different channels sharing a source are cycle-identical once both are in RUN.
//
// TESTING
//   1. Reset, then write ch0 = {1,3'd4}; io_clk_in[4] toggles every 5 cycles
//        -> ch_ready[0] rises after 8 enabled cycles
//        -> alternating rise/fall pulses, 1 cycle wide, each 3 cycles after the sampled toggle
//   2. ch1 in RUN on source 5; rewrite sel=6
//        -> ready drops next cycle, 8 cycles with no strobes, then strobes track io_clk_in[6] only
//        -> no pulse at the switch instant even when source 5=1 and source 6=0
//   3. ch2 = {1,3'd0}
//        -> after settle, rise_strobe[2]=1 every cycle, fall_strobe[2]=0
//        -> clk_en=0 for 3 cycles forces both to 0; FSM holds
//   4. Drop clk_en for 20 cycles while source 7 toggles
//        -> zero strobes during the gap
//        -> first strobe after resume corresponds only to an edge occurring after clk_en=1
//   5. Assert async_rst_n mid-SETTLE and mid-RUN
//        -> outputs 0 immediately; cfg_rdata=0
//        -> after release no strobes until reconfigured
//   6. Write cfg_addr=NUM_CH -> no channel changes, cfg_rdata=0; identical rewrite in RUN -> ready stays 1

Source files
------------

// File: rtl/io_clk_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module   : io_clk_strobe_gen
// Brief    : Converts selected IO clock sources into sys_clk-domain rise/fall
//            strobes per channel, with a settle blanking interval after every
//            enable or source change.
// Revision : 1.0 - initial release
// ============================================================================
module io_clk_strobe_gen #(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int ADDR_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              async_rst_n,
  input  logic              clk_en,
  input  logic [7:0]        io_clk_in,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_wdata,
  output logic [3:0]        cfg_rdata,
  output logic [NUM_CH-1:0] rise_strobe,
  output logic [NUM_CH-1:0] fall_strobe,
  output logic [NUM_CH-1:0] ch_ready
);

  localparam int               CNT_W      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);
  localparam logic [ADDR_W:0]  NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  // Source 0 is sys_clk itself and is never sampled.
  logic unused_sys_clk_in;
  assign unused_sys_clk_in = io_clk_in[0];

  logic [7:1][SYNC_STAGES-1:0] sync_d;
  logic [7:1][SYNC_STAGES-1:0] sync_q;
  logic [7:1]                  hist_d;
  logic [7:1]                  hist_q;
  logic [7:0]                  synced_vec;
  logic [7:0]                  hist_vec;
  logic                        addr_ok;
  logic [3:0]                  cfg_all [NUM_CH];

  // Next value of each source synchronizer chain and its one-cycle history.
  always_comb begin
    synced_vec = '0;
    for (int s = 1; s < 8; s++) begin
      sync_d[s]     = {sync_q[s][SYNC_STAGES-2:0], io_clk_in[s]};
      synced_vec[s] = sync_q[s][SYNC_STAGES-1];
    end
    hist_d = synced_vec[7:1];
  end

  // Bit 0 stays 0 so a sys_clk selection never yields a sampled edge.
  assign hist_vec = {hist_q, 1'b0};
  assign addr_ok  = ({1'b0, cfg_addr} < NUM_CH_EXT);

  // Free-running synchronizers and history; clk_en deliberately not used here.
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_d;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       cfg_d;
    logic [3:0]       cfg_q;
    logic             rise_d;
    logic             rise_q;
    logic             fall_d;
    logic             fall_q;
    logic             wr_hit;
    logic [2:0]       sel;
    logic             run;

    assign wr_hit = cfg_we && addr_ok && (cfg_addr == ADDR_W'(i));
    assign sel    = cfg_q[2:0];
    assign run    = (state_q == ST_RUN);

    // Channel FSM, settle counter and registered edge detection.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cfg_d   = cfg_q;

      if (clk_en && (state_q == ST_SETTLE)) begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end

      // A write overrides any settle progress made in the same cycle.
      if (wr_hit) begin
        cfg_d = cfg_wdata;
        if (!cfg_wdata[3]) begin
          state_d = ST_DISABLED;
          cnt_d   = '0;
        end else if ((state_q == ST_DISABLED) || (cfg_wdata[2:0] != cfg_q[2:0])) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_LOAD;
        end
      end

      rise_d = clk_en && run &&  synced_vec[sel] && !hist_vec[sel];
      fall_d = clk_en && run && !synced_vec[sel] &&  hist_vec[sel];
    end

    // Channel state registers.
    always_ff @(posedge sys_clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
        state_q <= ST_DISABLED;
        cnt_q   <= '0;
        cfg_q   <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        cfg_q   <= cfg_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    // Outputs are masked by RUN and the live clk_en so blanking is immediate.
    assign cfg_all[i]     = cfg_q;
    assign ch_ready[i]    = run;
    assign rise_strobe[i] = run && clk_en && ((sel == 3'd0) || rise_q);
    assign fall_strobe[i] = run && clk_en && (sel != 3'd0) && fall_q;
  end

  // Combinational config readback; out-of-range addresses read as zero.
  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_ok && (cfg_addr == ADDR_W'(i))) begin
        cfg_rdata = cfg_all[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_clk_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_clk_strobe_gen
// Brief    : Directed self-checking bench for io_clk_strobe_gen (3 channels,
//            so that an out-of-range config address exists).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_clk_strobe_gen;

  localparam int NCH = 3;

  logic           sys_clk = 1'b0;
  logic           async_rst_n;
  logic           clk_en;
  logic [7:0]     io_clk_in;
  logic [1:0]     cfg_addr;
  logic           cfg_we;
  logic [3:0]     cfg_wdata;
  logic [3:0]     cfg_rdata;
  logic [NCH-1:0] rise_strobe;
  logic [NCH-1:0] fall_strobe;
  logic [NCH-1:0] ch_ready;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  io_clk_strobe_gen #(
    .NUM_CH        (NCH),
    .SYNC_STAGES   (2),
    .SETTLE_CYCLES (8)
  ) u_dut (
    .sys_clk     (sys_clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .io_clk_in   (io_clk_in),
    .cfg_addr    (cfg_addr),
    .cfg_we      (cfg_we),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .rise_strobe (rise_strobe),
    .fall_strobe (fall_strobe),
    .ch_ready    (ch_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_we    = 1'b1;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [3:0] exp);
    cfg_addr = a;
    #1;
    chk(tag, 32'(cfg_rdata), 32'(exp));
  endtask

  // After the write edge: 7 cycles not ready, ready on the 8th.
  task automatic settle_chk(input string tag, input int ch);
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 7 || j == 8) chk(tag, 32'(ch_ready[ch]), 32'(j == 8));
    end
  endtask

  // Toggle a source; its strobe appears on the 3rd sampled cycle only.
  task automatic toggle_chk(input string tag, input int src, input int ch);
    logic       v;
    logic [1:0] exp;
    io_clk_in[src] = ~io_clk_in[src];
    v = io_clk_in[src];
    for (int j = 0; j < 5; j++) begin
      step();
      exp = (j == 2) ? (v ? 2'b10 : 2'b01) : 2'b00;
      chk(tag, 32'({rise_strobe[ch], fall_strobe[ch]}), 32'(exp));
    end
  endtask

  task automatic quiet_chk(input string tag, input int ch, input int n);
    for (int j = 0; j < n; j++) begin
      step();
      chk(tag, 32'({rise_strobe[ch], fall_strobe[ch]}), 32'd0);
    end
  endtask

  initial begin
    async_rst_n = 1'b0;
    clk_en      = 1'b1;
    io_clk_in   = '0;
    cfg_addr    = '0;
    cfg_we      = 1'b0;
    cfg_wdata   = '0;

    // Reset state
    step();
    step();
    chk("rst_ready", 32'(ch_ready), 32'd0);
    chk("rst_rise",  32'(rise_strobe), 32'd0);
    chk("rst_fall",  32'(fall_strobe), 32'd0);
    rd("rst_rdata", 2'd0, 4'h0);
    async_rst_n = 1'b1;
    step();

    // 1: ch0 on divided clk source 4
    wr(2'd0, 4'hC);
    rd("t1_rdata", 2'd0, 4'hC);
    chk("t1_settle0", 32'(ch_ready[0]), 32'd0);
    settle_chk("t1_ready", 0);
    for (int t = 0; t < 4; t++) toggle_chk("t1_strb", 4, 0);

    // 2: ch1 on source 5, then switch to source 6
    io_clk_in[5] = 1'b1;
    wr(2'd1, 4'hD);
    settle_chk("t2_ready5", 1);
    quiet_chk("t2_old_edge", 1, 3);
    toggle_chk("t2_s5", 5, 1);
    toggle_chk("t2_s5", 5, 1);
    io_clk_in[6] = 1'b0;
    wr(2'd1, 4'hE);
    chk("t2_drop", 32'(ch_ready[1]), 32'd0);
    chk("t2_sw_strb", 32'({rise_strobe[1], fall_strobe[1]}), 32'd0);
    io_clk_in[6] = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      if (j == 3) io_clk_in[5] = 1'b0;
      step();
      chk("t2_blank", 32'({rise_strobe[1], fall_strobe[1]}), 32'd0);
      if (j >= 7) chk("t2_ready6", 32'(ch_ready[1]), 32'(j == 8));
    end
    io_clk_in[5] = 1'b1;
    quiet_chk("t2_ignore5", 1, 5);
    toggle_chk("t2_s6", 6, 1);
    toggle_chk("t2_s6", 6, 1);

    // 3: ch2 on sys_clk
    wr(2'd2, 4'h8);
    settle_chk("t3_ready", 2);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t3_run", 32'({rise_strobe[2], fall_strobe[2]}), 32'b10);
    end
    clk_en = 1'b0;
    #1;
    chk("t3_gate", 32'({rise_strobe[2], fall_strobe[2]}), 32'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t3_gate", 32'({rise_strobe[2], fall_strobe[2]}), 32'd0);
      chk("t3_hold", 32'(ch_ready[2]), 32'd1);
    end
    clk_en = 1'b1;
    #1;
    chk("t3_resume", 32'({rise_strobe[2], fall_strobe[2]}), 32'b10);

    // 4: clk_en gap while source 7 toggles
    wr(2'd0, 4'hF);
    settle_chk("t4_ready", 0);
    clk_en = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if ((j % 3 == 0) && (j <= 15)) io_clk_in[7] = ~io_clk_in[7];
      step();
      chk("t4_gap", 32'({rise_strobe, fall_strobe}), 32'd0);
    end
    clk_en = 1'b1;
    quiet_chk("t4_no_stale", 0, 4);
    toggle_chk("t4_fresh", 7, 0);

    // 5: reset mid-SETTLE and mid-RUN
    wr(2'd1, 4'hD);
    step();
    step();
    async_rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(ch_ready), 32'd0);
    chk("t5_rst_rise",  32'(rise_strobe), 32'd0);
    chk("t5_rst_fall",  32'(fall_strobe), 32'd0);
    rd("t5_rst_rd0", 2'd0, 4'h0);
    rd("t5_rst_rd1", 2'd1, 4'h0);
    step();
    async_rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      io_clk_in[7:4] = ~io_clk_in[7:4];
      step();
      chk("t5_idle", 32'({ch_ready, rise_strobe, fall_strobe}), 32'd0);
    end
    wr(2'd2, 4'h8);
    settle_chk("t5_run", 2);
    step();
    chk("t5_run_rise", 32'(rise_strobe[2]), 32'd1);
    async_rst_n = 1'b0;
    #1;
    chk("t5_rst2_ready", 32'(ch_ready), 32'd0);
    chk("t5_rst2_rise",  32'(rise_strobe), 32'd0);
    rd("t5_rst2_rd2", 2'd2, 4'h0);
    step();
    async_rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("t5_idle2", 32'({ch_ready, rise_strobe, fall_strobe}), 32'd0);
    end

    // 6: out-of-range write and identical rewrite
    wr(2'd0, 4'hC);
    settle_chk("t6_ready", 0);
    wr(2'd3, 4'hF);
    rd("t6_rd3", 2'd3, 4'h0);
    rd("t6_rd0", 2'd0, 4'hC);
    rd("t6_rd1", 2'd1, 4'h0);
    rd("t6_rd2", 2'd2, 4'h0);
    chk("t6_ready_all", 32'(ch_ready), 32'b001);
    wr(2'd0, 4'hC);
    chk("t6_same", 32'(ch_ready[0]), 32'd1);
    for (int j = 0; j < 4; j++) step();
    chk("t6_same_hold", 32'(ch_ready[0]), 32'd1);
    toggle_chk("t6_strb", 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
